// File: rtl/mod4_down_seq_monitor.sv
// Sequence monitor for a 2-bit MOD-4 down counter: checks 3->2->1->0->3, declares lock, counts wraps and errors.
// Optional build macro HOLD_TOL_EN: when defined, a repeated sample (hold) is ignored instead of flagged as an error.
module mod4_down_seq_monitor #(
  parameter int unsigned LOCK_N = 4,
  parameter int unsigned WRAP_W = 8,
  parameter int unsigned ERR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        count_in,
  input  logic              count_valid,
  output logic              locked,
  output logic              tc_pulse,
  output logic              err_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic [ERR_W-1:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

`ifdef HOLD_TOL_EN
  localparam bit HoldTol = 1'b1;
`else
  localparam bit HoldTol = 1'b0;
`endif

  // LOCK_N is limited to 1..15, so a 4-bit run counter never overflows.
  localparam logic [3:0] LockLim = 4'(LOCK_N);

  state_t     state;
  logic [1:0] prev;
  logic [3:0] run;

  logic [1:0] exp_next;
  logic [3:0] run_inc;
  logic       is_correct;
  logic       is_wrap;
  logic       is_error;

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    exp_next   = prev - 2'd1;
    run_inc    = run + 4'd1;
    is_correct = (count_in == exp_next);
    is_wrap    = is_correct && (prev == 2'd0);
    is_error   = !is_correct && !(HoldTol && (count_in == prev));
  end

  // NOTE: all state and outputs update with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      prev       <= 2'd0;
      run        <= 4'd0;
      locked     <= 1'b0;
      tc_pulse   <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_count <= '0;
      err_count  <= '0;
    end else begin
      tc_pulse  <= 1'b0;
      err_pulse <= 1'b0;
      if (count_valid) begin
        unique case (state)
          IDLE: begin
            prev  <= count_in;
            run   <= 4'd0;
            state <= ACQ;
          end
          ACQ: begin
            if (is_correct) begin
              prev     <= count_in;
              run      <= run_inc;
              tc_pulse <= is_wrap;
              if (run_inc >= LockLim) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else if (is_error) begin
              prev      <= count_in;
              run       <= 4'd0;
              err_pulse <= 1'b1;
              if (err_count != '1) err_count <= err_count + ERR_W'(1);
            end
          end
          LOCKED: begin
            if (is_correct) begin
              prev     <= count_in;
              tc_pulse <= is_wrap;
              // Wraps are counted only once lock is established; the locking edge itself does not count.
              if (is_wrap) wrap_count <= wrap_count + WRAP_W'(1);
            end else if (is_error) begin
              prev      <= count_in;
              run       <= 4'd0;
              err_pulse <= 1'b1;
              state     <= ACQ;
              locked    <= 1'b0;
              if (err_count != '1) err_count <= err_count + ERR_W'(1);
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
